// File: rtl/gauss_pkg.sv
// gauss_pkg: shared FSM encoding, image geometry defaults and request vector type
package gauss_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_DONE} state_e;
    typedef logic [1:0] req_t;
    localparam int unsigned IMG_WIDTH_DEF  = 1920;
    localparam int unsigned IMG_HEIGHT_DEF = 1080;
    localparam int unsigned CNT_W          = 12;
endpackage

// File: rtl/gauss_rr_arb2.sv
// gauss_rr_arb2: two-way round-robin pick; pointer resets as if 1 won last so 0 wins first
module gauss_rr_arb2
    import gauss_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  req_t req,
    input  logic take,
    output logic win
);
    logic last_q, last_d;

    always_comb begin
        win    = (&req) ? !last_q : req[1];
        last_d = take ? win : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b1;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/gauss_frame_arbiter.sv
// gauss_frame_arbiter: time-shares one Gaussian stage between two pixel streams,
// one whole frame at a time, with framing checks and per-requester frame counts.
module gauss_frame_arbiter
    import gauss_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s0_tdata,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    input  logic        s0_tuser,
    output logic        s0_tready,
    input  logic [7:0]  s1_tdata,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    input  logic        s1_tuser,
    output logic        s1_tready,
    output logic [7:0]  g_tdata,
    output logic        g_tvalid,
    output logic        g_tlast,
    output logic        g_tuser,
    input  logic        g_tready,
    input  logic [7:0]  r_tdata,
    input  logic        r_tvalid,
    input  logic        r_tlast,
    input  logic        r_tuser,
    output logic        r_tready,
    output logic [7:0]  m0_tdata,
    output logic        m0_tvalid,
    output logic        m0_tlast,
    output logic        m0_tuser,
    input  logic        m0_tready,
    output logic [7:0]  m1_tdata,
    output logic        m1_tvalid,
    output logic        m1_tlast,
    output logic        m1_tuser,
    input  logic        m1_tready,
    input  logic [1:0]  en,
    output logic        busy,
    output logic        grant_id,
    output logic        frame_done,
    output logic        frame_done_id,
    output logic        err_sof,
    output logic        err_len,
    output logic        sync_drop,
    output logic [15:0] frame_cnt0,
    output logic [15:0] frame_cnt1
);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] LINES    = CNT_W'(IMG_HEIGHT);

    state_e           state_q, state_d;
    logic             grant_q, grant_d, first_q, first_d, win;
    logic [CNT_W-1:0] col_q, col_d, in_line_q, in_line_d, out_line_q, out_line_d;
    logic [15:0]      fcnt0_q, fcnt0_d, fcnt1_q, fcnt1_d;
    logic             frame_done_q, frame_done_d, frame_done_id_q, frame_done_id_d;
    logic             err_sof_q, err_sof_d, err_len_q, err_len_d, sync_drop_q, sync_drop_d;
    req_t             elig, drop;
    logic             idle, feed, act, done, g_hs, r_hs, col_last;

    gauss_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (elig),
        .take (|elig),
        .win  (win)
    );

    // Stream routing; handshakes are held off while rst is asserted
    always_comb begin
        idle      = state_q == ST_IDLE;
        feed      = state_q == ST_FEED && !rst;
        act       = (state_q == ST_FEED || state_q == ST_DRAIN) && !rst;
        elig      = idle ? {en[1] & s1_tvalid & s1_tuser, en[0] & s0_tvalid & s0_tuser} : 2'b00;
        drop      = (idle && !rst) ? {en[1] & s1_tvalid & ~s1_tuser, en[0] & s0_tvalid & ~s0_tuser} : 2'b00;
        g_tdata   = grant_q ? s1_tdata : s0_tdata;
        g_tlast   = grant_q ? s1_tlast : s0_tlast;
        g_tuser   = grant_q ? s1_tuser : s0_tuser;
        g_tvalid  = feed && (grant_q ? s1_tvalid : s0_tvalid);
        s0_tready = drop[0] || (feed && !grant_q && g_tready);
        s1_tready = drop[1] || (feed && grant_q && g_tready);
        r_tready  = act && (grant_q ? m1_tready : m0_tready);
        m0_tdata  = r_tdata;
        m0_tlast  = r_tlast;
        m0_tuser  = r_tuser;
        m0_tvalid = act && !grant_q && r_tvalid;
        m1_tdata  = r_tdata;
        m1_tlast  = r_tlast;
        m1_tuser  = r_tuser;
        m1_tvalid = act && grant_q && r_tvalid;
        busy          = !idle;
        grant_id      = grant_q;
        frame_done    = frame_done_q;
        frame_done_id = frame_done_id_q;
        err_sof       = err_sof_q;
        err_len       = err_len_q;
        sync_drop     = sync_drop_q;
        frame_cnt0    = fcnt0_q;
        frame_cnt1    = fcnt1_q;
    end

    // Completion needs both sides at IMG_HEIGHT lines, possibly in the same cycle
    always_comb begin
        done       = state_q == ST_DONE;
        g_hs       = g_tvalid && g_tready;
        r_hs       = r_tvalid && r_tready;
        col_last   = col_q == COL_LAST;
        col_d      = (done || (g_hs && (g_tlast || col_last))) ? '0 : col_q + CNT_W'(g_hs);
        in_line_d  = done ? '0 : in_line_q + CNT_W'(g_hs && g_tlast);
        out_line_d = done ? '0 : out_line_q + CNT_W'(r_hs && r_tlast);
        state_d    = idle ? (|elig ? ST_FEED : ST_IDLE)
                   : done ? ST_IDLE
                   : (in_line_d == LINES && out_line_d == LINES) ? ST_DONE
                   : (in_line_d == LINES) ? ST_DRAIN : state_q;
        grant_d         = |elig ? win : grant_q;
        first_d         = idle || (first_q && !g_hs);
        err_len_d       = g_hs && (g_tlast != col_last);
        err_sof_d       = g_hs && g_tuser && !first_q;
        sync_drop_d     = |drop;
        frame_done_d    = state_d == ST_DONE;
        frame_done_id_d = frame_done_d ? grant_q : frame_done_id_q;
        fcnt0_d         = fcnt0_q + 16'(done && !grant_q);
        fcnt1_d         = fcnt1_q + 16'(done && grant_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            grant_q         <= 1'b0;
            first_q         <= 1'b1;
            col_q           <= '0;
            in_line_q       <= '0;
            out_line_q      <= '0;
            fcnt0_q         <= '0;
            fcnt1_q         <= '0;
            frame_done_q    <= 1'b0;
            frame_done_id_q <= 1'b0;
            err_sof_q       <= 1'b0;
            err_len_q       <= 1'b0;
            sync_drop_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            first_q         <= first_d;
            col_q           <= col_d;
            in_line_q       <= in_line_d;
            out_line_q      <= out_line_d;
            fcnt0_q         <= fcnt0_d;
            fcnt1_q         <= fcnt1_d;
            frame_done_q    <= frame_done_d;
            frame_done_id_q <= frame_done_id_d;
            err_sof_q       <= err_sof_d;
            err_len_q       <= err_len_d;
            sync_drop_q     <= sync_drop_d;
        end
    end
endmodule

// File: tb/tb_gauss_frame_arbiter.sv
// tb_gauss_frame_arbiter: random streams through a fixed-latency stage model,
// checked every cycle against a frame-level behavioural model and scoreboards.
module tb_gauss_frame_arbiter;
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 3;

    typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
    typedef struct {beat_t b; int t;} st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] s0_tdata = '0, s1_tdata = '0, g_tdata, r_tdata = '0, m0_tdata, m1_tdata;
    logic s0_tvalid = 0, s0_tlast = 0, s0_tuser = 0, s0_tready;
    logic s1_tvalid = 0, s1_tlast = 0, s1_tuser = 0, s1_tready;
    logic g_tvalid, g_tlast, g_tuser, g_tready = 0;
    logic r_tvalid = 0, r_tlast = 0, r_tuser = 0, r_tready;
    logic m0_tvalid, m0_tlast, m0_tuser, m0_tready = 0;
    logic m1_tvalid, m1_tlast, m1_tuser, m1_tready = 0;
    logic [1:0] en = 2'b11;
    logic busy, grant_id, frame_done, frame_done_id, err_sof, err_len, sync_drop;
    logic [15:0] frame_cnt0, frame_cnt1;

    always #5 clk = ~clk;

    gauss_frame_arbiter #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser), .s1_tready(s1_tready),
        .g_tdata(g_tdata), .g_tvalid(g_tvalid), .g_tlast(g_tlast), .g_tuser(g_tuser), .g_tready(g_tready),
        .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tlast(r_tlast), .r_tuser(r_tuser), .r_tready(r_tready),
        .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tlast(m0_tlast), .m0_tuser(m0_tuser), .m0_tready(m0_tready),
        .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tlast(m1_tlast), .m1_tuser(m1_tuser), .m1_tready(m1_tready),
        .en(en), .busy(busy), .grant_id(grant_id), .frame_done(frame_done), .frame_done_id(frame_done_id),
        .err_sof(err_sof), .err_len(err_len), .sync_drop(sync_drop),
        .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1)
    );

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 0;
    int cyc = 0;
    int src_pct = 100, g_pct = 100;
    int m_pct[2] = '{100, 100};
    beat_t src_q[2][$];
    beat_t sb_q[2][$];
    st_t   stage_q[$];
    logic [1:0] cur_v = '0;

    // Behavioural model: phase 0 idle, 1 feeding, 2 draining, 3 finishing
    int md_ph = 0, md_in = 0, md_out = 0, md_col = 0;
    logic md_gnt = 0, md_last = 1, md_first = 1;
    logic x_done = 0, x_done_id = 0, x_sof = 0, x_len = 0, x_drop = 0;
    logic [15:0] x_fc[2] = '{16'd0, 16'd0};
    logic [1:0] hs_s = '0, cap_e = '0;
    logic hs_g = 0, hs_r = 0, gl = 0, gu = 0, rl = 0;

    int n_done[2], n_m[2], n_mlast[2], n_muser[2];
    int n_drop, n_len, n_sof, n_g, exp_len_cnt, exp_sof_cnt;
    logic done_order[$];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [1:0] sv, su, sl, xs, xmv, mr, ml, mu;
        logic [7:0] sd[2];
        logic [7:0] md[2];
        logic xgv, xrr, idle, feed, act;
        beat_t b;
        if (chk_on) begin
            sv = {s1_tvalid, s0_tvalid}; su = {s1_tuser, s0_tuser}; sl = {s1_tlast, s0_tlast};
            sd[0] = s0_tdata; sd[1] = s1_tdata; md[0] = m0_tdata; md[1] = m1_tdata;
            mr = {m1_tready, m0_tready}; ml = {m1_tlast, m0_tlast}; mu = {m1_tuser, m0_tuser};
            idle = md_ph == 0 && !rst;
            feed = md_ph == 1 && !rst;
            act  = (md_ph == 1 || md_ph == 2) && !rst;
            for (int k = 0; k < 2; k++) begin
                xs[k]  = idle ? (en[k] && sv[k] && !su[k]) : (feed && md_gnt == k && g_tready);
                xmv[k] = act && md_gnt == k && r_tvalid;
            end
            xgv = feed && sv[md_gnt];
            xrr = act && mr[md_gnt];
            chk("s0_tready", s0_tready, xs[0]);
            chk("s1_tready", s1_tready, xs[1]);
            chk("g_tvalid", g_tvalid, xgv);
            chk("r_tready", r_tready, xrr);
            chk("m0_tvalid", m0_tvalid, xmv[0]);
            chk("m1_tvalid", m1_tvalid, xmv[1]);
            chk("busy", busy, md_ph != 0);
            chk("grant_id", grant_id, md_gnt);
            chk("frame_done", frame_done, x_done);
            chk("frame_done_id", frame_done_id, x_done_id);
            chk("err_sof", err_sof, x_sof);
            chk("err_len", err_len, x_len);
            chk("sync_drop", sync_drop, x_drop);
            chk("frame_cnt0", frame_cnt0, x_fc[0]);
            chk("frame_cnt1", frame_cnt1, x_fc[1]);
            if (xgv) chk("g_beat", {g_tdata, g_tlast, g_tuser}, {sd[md_gnt], sl[md_gnt], su[md_gnt]});
            for (int k = 0; k < 2; k++)
                if (xmv[k] && mr[k]) begin
                    if (sb_q[k].size() == 0) chk("m_extra_beat", {31'd0, 1'b1}, 32'd0);
                    else begin
                        b = sb_q[k].pop_front();
                        chk(k ? "m1_beat" : "m0_beat", {md[k], ml[k], mu[k]}, {b.d, b.l, b.u});
                    end
                    n_m[k]++; n_mlast[k] += ml[k]; n_muser[k] += mu[k];
                end
            hs_s  = sv & xs;
            hs_g  = xgv && g_tready;
            hs_r  = r_tvalid && xrr;
            cap_e = {2{idle}} & en & sv & su;
            gl = sl[md_gnt]; gu = su[md_gnt]; rl = r_tlast;
            if (hs_g) begin
                b = '{d: sd[md_gnt], l: sl[md_gnt], u: su[md_gnt]};
                sb_q[md_gnt].push_back(b);
                stage_q.push_back('{b: b, t: cyc + LAT});
                n_g++;
            end
            if (frame_done) begin n_done[frame_done_id]++; done_order.push_back(frame_done_id); end
            n_drop += sync_drop; n_len += err_len; n_sof += err_sof;
        end
    end

    task automatic upd();
        logic w;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin src_q[k].delete(); sb_q[k].delete(); x_fc[k] = '0; end
            stage_q.delete(); cur_v = '0;
            md_ph = 0; md_gnt = 0; md_last = 1; md_first = 1; md_in = 0; md_out = 0; md_col = 0;
            x_done = 0; x_done_id = 0; x_sof = 0; x_len = 0; x_drop = 0;
            return;
        end
        for (int k = 0; k < 2; k++)
            if (hs_s[k] && src_q[k].size() > 0) begin void'(src_q[k].pop_front()); cur_v[k] = 0; end
        if (hs_r && stage_q.size() > 0) void'(stage_q.pop_front());
        x_sof = 0; x_len = 0; x_drop = 0; x_done = 0;
        if (md_ph == 0) begin
            x_drop = |hs_s;
            if (|cap_e) begin
                w = (cap_e == 2'b11) ? !md_last : cap_e[1];
                md_gnt = w; md_last = w; md_ph = 1; md_first = 1;
            end
        end else if (md_ph == 3) begin
            x_fc[md_gnt]++;
            md_ph = 0; md_in = 0; md_out = 0; md_col = 0;
        end else begin
            if (hs_g) begin
                if (gu && !md_first) x_sof = 1;
                md_first = 0;
                if (gl || md_col == W - 1) begin
                    x_len = gl != (md_col == W - 1);
                    md_col = 0;
                    md_in += gl;
                end else md_col++;
            end
            if (hs_r && rl) md_out++;
            if (md_in == H && md_out == H) begin md_ph = 3; x_done = 1; x_done_id = md_gnt; end
            else if (md_in == H) md_ph = 2;
        end
    endtask

    task automatic drive();
        beat_t b[2];
        for (int k = 0; k < 2; k++) begin
            if (!cur_v[k] && src_q[k].size() > 0 && $urandom_range(99) < src_pct) cur_v[k] = 1;
            b[k] = src_q[k].size() > 0 ? src_q[k][0] : '0;
        end
        s0_tvalid = cur_v[0]; {s0_tdata, s0_tlast, s0_tuser} = b[0];
        s1_tvalid = cur_v[1]; {s1_tdata, s1_tlast, s1_tuser} = b[1];
        g_tready  = $urandom_range(99) < g_pct;
        m0_tready = $urandom_range(99) < m_pct[0];
        m1_tready = $urandom_range(99) < m_pct[1];
        if (stage_q.size() > 0 && stage_q[0].t <= cyc) begin
            r_tvalid = 1; {r_tdata, r_tlast, r_tuser} = stage_q[0].b;
        end else begin
            r_tvalid = 0; {r_tdata, r_tlast, r_tuser} = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        upd();
        cyc++;
        #1 drive();
    endtask

    task automatic do_reset();
        rst = 1; step(); step(); rst = 0; step();
    endtask

    task automatic reset_stats();
        for (int k = 0; k < 2; k++) begin n_done[k] = 0; n_m[k] = 0; n_mlast[k] = 0; n_muser[k] = 0; end
        n_drop = 0; n_len = 0; n_sof = 0; n_g = 0; exp_len_cnt = 0; exp_sof_cnt = 0;
        done_order.delete();
    endtask

    task automatic push_frame(input int k, input int short_line, input int short_len, input int bad_u);
        beat_t b;
        int idx = 0;
        for (int l = 0; l < H; l++) begin
            int len;
            len = (l == short_line) ? short_len : W;
            if (len != W) exp_len_cnt++;
            for (int c = 0; c < len; c++) begin
                b.d = 8'($urandom);
                b.l = c == len - 1;
                b.u = idx == 0 || idx == bad_u;
                if (idx != 0 && idx == bad_u) exp_sof_cnt++;
                src_q[k].push_back(b);
                idx++;
            end
        end
    endtask

    task automatic push_junk(input int k, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = 8'($urandom); b.l = 1'($urandom); b.u = 0;
            src_q[k].push_back(b);
        end
    endtask

    function automatic bit quiet();
        return md_ph == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 && stage_q.size() == 0;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin step(); n++; end
        repeat (4) step();
        if (n >= budget) begin
            n_cmp++; n_bad++;
            $display("FAIL run_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    initial begin
        int frames, n;
        do_reset();
        chk_on = 1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant_id, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_g_tvalid", g_tvalid, 0);

        // single frame on requester 0, all readies high
        reset_stats();
        push_frame(0, -1, 0, -1);
        run(500);
        chk("f1_done0", n_done[0], 1);
        chk("f1_done1", n_done[1], 0);
        chk("f1_beats", n_m[0], 32);
        chk("f1_tlasts", n_mlast[0], 4);
        chk("f1_tusers", n_muser[0], 1);
        chk("f1_frame_cnt0", frame_cnt0, 1);

        // simultaneous SOF right after reset: 0 then 1
        do_reset();
        reset_stats();
        push_frame(0, -1, 0, -1);
        push_frame(1, -1, 0, -1);
        run(1000);
        chk("rr_count", done_order.size(), 2);
        if (done_order.size() == 2) begin
            chk("rr_first", done_order[0], 0);
            chk("rr_second", done_order[1], 1);
        end
        chk("rr_beats1", n_m[1], 32);

        // non-SOF beats while idle are dropped
        reset_stats();
        push_junk(1, 3);
        run(100);
        chk("drop_pulses", n_drop, 3);
        chk("drop_no_g", n_g, 0);

        // short line 2 (tlast at column 5) plus stray tuser at pixel 13
        reset_stats();
        push_frame(0, 2, 6, 13);
        run(500);
        chk("len_err", n_len, 1);
        chk("sof_err", n_sof, 1);
        chk("len_beats", n_m[0], 30);
        chk("len_done", n_done[0], 1);

        // m0 back-pressure 50%
        reset_stats();
        m_pct[0] = 50;
        push_frame(0, -1, 0, -1);
        run(1000);
        m_pct[0] = 100;
        chk("bp_beats", n_m[0], 32);
        chk("bp_done", n_done[0], 1);

        // randomized mix
        reset_stats();
        frames = 0;
        for (int i = 0; i < 10; i++) begin
            int k;
            k = $urandom_range(1);
            if ($urandom_range(3) == 0) push_junk(k, $urandom_range(1, 3));
            push_frame(k, ($urandom_range(3) == 0) ? int'($urandom_range(H - 1)) : -1,
                       $urandom_range(1, W), ($urandom_range(3) == 0) ? int'($urandom_range(1, 20)) : -1);
            frames++;
        end
        src_pct = 70; g_pct = 60; m_pct[0] = 60; m_pct[1] = 75;
        n = 0;
        while (!quiet() && n < 20000) begin
            step(); n++;
            if ($urandom_range(19) == 0) en = 2'($urandom_range(3));
        end
        en = 2'b11;
        run(5000);
        src_pct = 100; g_pct = 100; m_pct[0] = 100; m_pct[1] = 100;
        chk("rnd_frames", n_done[0] + n_done[1], frames);
        chk("rnd_len", n_len, exp_len_cnt);
        chk("rnd_sof", n_sof, exp_sof_cnt);
        chk("rnd_sb_empty", sb_q[0].size() + sb_q[1].size(), 0);

        // reset mid-frame after 10 pixels
        reset_stats();
        push_frame(0, -1, 0, -1);
        n = 0;
        while (n_g < 10 && n < 200) begin step(); n++; end
        chk("mid_reached10", n_g, 10);
        rst = 1; step(); rst = 0;
        @(negedge clk);
        chk("mid_busy", busy, 0);
        chk("mid_s0_tready", s0_tready, 0);
        chk("mid_r_tready", r_tready, 0);
        chk("mid_g_tvalid", g_tvalid, 0);
        repeat (20) step();
        chk("mid_no_done", n_done[0] + n_done[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
